// File: rtl/muldiv_hazard_ctrl.sv
// rtl/muldiv_hazard_ctrl.sv - pipeline hazard control with multi-cycle mul/div scheduler
module muldiv_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic [4:0]  EX_WR_out,
    input  logic        EX_MemtoReg,
    input  logic [1:0]  EX_JumpOP,
    input  logic        EX_MDReq,
    input  logic        EX_MDIsDiv,
    output logic        PCWrite,
    output logic        IF_IDWrite,
    output logic        ID_EXWrite,
    output logic        IF_Flush,
    output logic        ID_Flush,
    output logic        MD_Start,
    output logic        MD_Busy,
    output logic [15:0] StallCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter preload is latency-1: the IDLE cycle that issues the start is the first freeze cycle.
    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [15:0]       r_stall_cnt;

    logic              w_md_issue;
    logic              w_eval_hazard;
    logic              w_jump;
    logic              w_load_use;
    logic [CNT_W-1:0]  w_lat_init;

    assign w_lat_init = EX_MDIsDiv ? DIV_INIT : MUL_INIT;
    assign w_jump     = (EX_JumpOP != 2'b00);
    assign w_load_use = EX_MemtoReg && (EX_WR_out != 5'd0) &&
                        ((EX_WR_out == ID_Rs) || (EX_WR_out == ID_Rt));

    // A new mul/div is only accepted from IDLE; in DONE the same instruction still sits in EX.
    assign w_md_issue    = (r_state == S_IDLE) && EX_MDReq;
    assign w_eval_hazard = ((r_state == S_IDLE) && !EX_MDReq) || (r_state == S_DONE);

    // Combinational pipeline controls from current state and hazard inputs.
    always_comb begin
        PCWrite    = 1'b1;
        IF_IDWrite = 1'b1;
        ID_EXWrite = 1'b1;
        IF_Flush   = 1'b0;
        ID_Flush   = 1'b0;
        MD_Start   = 1'b0;
        MD_Busy    = 1'b0;
        if (!rst) begin
            if (w_md_issue) begin
                MD_Start   = 1'b1;
                MD_Busy    = 1'b1;
                PCWrite    = 1'b0;
                IF_IDWrite = 1'b0;
                ID_EXWrite = 1'b0;
            end else if (r_state == S_RUN) begin
                MD_Busy    = 1'b1;
                PCWrite    = 1'b0;
                IF_IDWrite = 1'b0;
                ID_EXWrite = 1'b0;
            end else if (w_eval_hazard) begin
                if (w_jump) begin
                    // The ID instruction is flushed, so a concurrent load-use match is moot.
                    IF_Flush = 1'b1;
                    ID_Flush = 1'b1;
                end else if (w_load_use) begin
                    PCWrite    = 1'b0;
                    IF_IDWrite = 1'b0;
                    ID_Flush   = 1'b1;
                end
            end
        end
    end

    // Mul/div sequencer state and latency counter; unknown encodings fall back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (EX_MDReq) begin
                        r_cnt   <= w_lat_init;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (!PCWrite && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_muldiv_hazard_ctrl.sv
// tb/tb_muldiv_hazard_ctrl.sv - randomized and directed check of muldiv_hazard_ctrl against a reference model
module tb_muldiv_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic [4:0]  EX_WR_out;
    logic        EX_MemtoReg;
    logic [1:0]  EX_JumpOP;
    logic        EX_MDReq;
    logic        EX_MDIsDiv;
    logic        PCWrite;
    logic        IF_IDWrite;
    logic        ID_EXWrite;
    logic        IF_Flush;
    logic        ID_Flush;
    logic        MD_Start;
    logic        MD_Busy;
    logic [15:0] StallCount;

    int n_vec;
    int n_err;

    // Reference model: remaining frozen cycles, release-cycle flag, stall total
    int m_freeze;
    bit m_release;
    int m_stall;

    muldiv_hazard_ctrl #(
        .MUL_CYCLES(4),
        .DIV_CYCLES(8),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ID_Rs(ID_Rs),
        .ID_Rt(ID_Rt),
        .EX_WR_out(EX_WR_out),
        .EX_MemtoReg(EX_MemtoReg),
        .EX_JumpOP(EX_JumpOP),
        .EX_MDReq(EX_MDReq),
        .EX_MDIsDiv(EX_MDIsDiv),
        .PCWrite(PCWrite),
        .IF_IDWrite(IF_IDWrite),
        .ID_EXWrite(ID_EXWrite),
        .IF_Flush(IF_Flush),
        .ID_Flush(ID_Flush),
        .MD_Start(MD_Start),
        .MD_Busy(MD_Busy),
        .StallCount(StallCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs are already applied; check this cycle's outputs, advance the model, move to next negedge.
    task automatic step();
        bit e_pc, e_ifid, e_idex, e_iff, e_idf, e_st, e_busy;
        int lat;
        #1;
        e_pc = 1; e_ifid = 1; e_idex = 1; e_iff = 0; e_idf = 0; e_st = 0; e_busy = 0;
        lat = EX_MDIsDiv ? 8 : 4;
        if (!rst) begin
            if (m_freeze > 0) begin
                e_busy = 1; e_pc = 0; e_ifid = 0; e_idex = 0;
            end else if (!m_release && EX_MDReq) begin
                e_st = 1; e_busy = 1; e_pc = 0; e_ifid = 0; e_idex = 0;
            end else if (EX_JumpOP != 0) begin
                e_iff = 1; e_idf = 1;
            end else if (EX_MemtoReg && EX_WR_out != 0 &&
                         (EX_WR_out == ID_Rs || EX_WR_out == ID_Rt)) begin
                e_pc = 0; e_ifid = 0; e_idf = 1;
            end
        end
        check_val("PCWrite",    32'(PCWrite),    32'(e_pc));
        check_val("IF_IDWrite", 32'(IF_IDWrite), 32'(e_ifid));
        check_val("ID_EXWrite", 32'(ID_EXWrite), 32'(e_idex));
        check_val("IF_Flush",   32'(IF_Flush),   32'(e_iff));
        check_val("ID_Flush",   32'(ID_Flush),   32'(e_idf));
        check_val("MD_Start",   32'(MD_Start),   32'(e_st));
        check_val("MD_Busy",    32'(MD_Busy),    32'(e_busy));
        check_val("StallCount", 32'(StallCount), 32'(m_stall));
        if (rst) begin
            m_freeze  = 0;
            m_release = 0;
            m_stall   = 0;
        end else begin
            if (!e_pc && m_stall < 65535) m_stall++;
            if (m_freeze > 0) begin
                m_freeze--;
                m_release = (m_freeze == 0);
            end else if (!m_release && EX_MDReq) begin
                m_freeze  = lat - 1;
                m_release = 0;
            end else begin
                m_release = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] wr, input bit mtr, input logic [1:0] jop,
                         input bit mdreq, input bit isdiv);
        rst = r; ID_Rs = rs; ID_Rt = rt; EX_WR_out = wr; EX_MemtoReg = mtr;
        EX_JumpOP = jop; EX_MDReq = mdreq; EX_MDIsDiv = isdiv;
        step();
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_freeze = 0; m_release = 0; m_stall = 0;
        rst = 1; ID_Rs = 0; ID_Rt = 0; EX_WR_out = 0; EX_MemtoReg = 0;
        EX_JumpOP = 0; EX_MDReq = 0; EX_MDIsDiv = 0;
        @(negedge clk);
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_val("reset_stall", 32'(StallCount), 32'd0);

        // Load-use on rt, then a zero destination that must not stall
        for (int i = 0; i < 3; i++) drive(0, 3, 5, 5, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        check_val("loaduse_stall", 32'(StallCount), 32'd3);

        // Jump wins over load-use
        drive(0, 7, 1, 7, 1, 2'b01, 0, 0);
        check_val("jump_stall", 32'(StallCount), 32'd3);

        // Multiply held through its release cycle
        do_reset();
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_val("mul_stall", 32'(StallCount), 32'd4);

        // Two back-to-back divides
        do_reset();
        for (int i = 0; i < 17; i++) drive(0, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_val("div2_stall", 32'(StallCount), 32'd16);

        // Reset on the third freeze cycle of a divide, then a fresh full divide
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 0, 0, 1, 1);
        check_val("midreset_stall", 32'(StallCount), 32'd0);
        for (int i = 0; i < 9; i++) drive(0, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_val("div_after_reset", 32'(StallCount), 32'd8);

        // Random mix of hazards, mul/div requests and occasional resets
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 49) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
        end

        // Saturation under sustained load-use
        do_reset();
        for (int i = 0; i < 65540; i++) drive(0, 9, 2, 9, 1, 0, 0, 0);
        check_val("sat_stall", 32'(StallCount), 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_hazard_ctrl.md
Name: muldiv_hazard_ctrl

Overview:
Pipeline control sequencer for the 5-stage core. It extends load-use and jump hazard handling with a multi-cycle multiply/divide scheduler in EX. A small FSM and latency counter freeze PC, IF/ID and ID/EX while the mul/div unit runs, and issue the unit's start pulse. A saturating stall counter supports performance measurement.

Parameters:
MUL_CYCLES, 4, multiply latency in cycles (>=2)
DIV_CYCLES, 8, divide latency in cycles (>=2)
CNT_W, 4, latency counter width (must hold DIV_CYCLES-1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
ID_Rs  input  5  rs of instruction in ID
ID_Rt  input  5  rt of instruction in ID
EX_WR_out  input  5  destination register of instruction in EX
EX_MemtoReg  input  1  EX instruction is a load
EX_JumpOP  input  2  nonzero = taken jump/branch resolved in EX
EX_MDReq  input  1  EX instruction is mul/div
EX_MDIsDiv  input  1  1 = divide, 0 = multiply (valid with EX_MDReq)
PCWrite  output  1  PC update enable
IF_IDWrite  output  1  IF/ID register enable
ID_EXWrite  output  1  ID/EX register enable
IF_Flush  output  1  clear IF/ID
ID_Flush  output  1  clear ID/EX controls (bubble)
MD_Start  output  1  one-cycle start pulse to mul/div unit
MD_Busy  output  1  mul/div in progress
StallCount  output  16  saturating count of cycles with PCWrite=0

Behaviour:
- Reset (rst=1 at edge): state<=IDLE, cnt<=0, StallCount<=0.
- While rst=1, outputs are forced to defaults: PCWrite=1, IF_IDWrite=1, ID_EXWrite=1, IF_Flush=0, ID_Flush=0, MD_Start=0, MD_Busy=0.
- Control outputs are combinational from state and inputs. StallCount is registered.
- Defaults (all states): PCWrite=1, IF_IDWrite=1, ID_EXWrite=1, flushes=0, MD_Start=0, MD_Busy=0.
- LAT = EX_MDIsDiv ? DIV_CYCLES : MUL_CYCLES.
- IDLE:
  - EX_MDReq=1 (highest priority):
    - MD_Start=1, MD_Busy=1, PCWrite=0, IF_IDWrite=0, ID_EXWrite=0.
    - Flushes=0; jump and load-use are ignored.
    - cnt<=LAT-1; next state MD_RUN.
  - Else EX_JumpOP!=0: IF_Flush=1, ID_Flush=1, PCWrite=1. A simultaneous load-use match is ignored because the ID instruction is flushed.
  - Else load-use: EX_MemtoReg=1, EX_WR_out!=0, and (EX_WR_out==ID_Rs or EX_WR_out==ID_Rt).
    - PCWrite=0, IF_IDWrite=0, ID_Flush=1 (bubble into EX).
    - No stall when EX_WR_out==0.
- MD_RUN:
  - MD_Busy=1; PCWrite, IF_IDWrite, ID_EXWrite all 0; flushes 0.
  - All hazard inputs are ignored.
  - If cnt==1, next state MD_DONE; else cnt<=cnt-1.
- MD_DONE:
  - Pipeline released; MD_Busy=0.
  - EX_MDReq is ignored, since the same instruction is still in EX and must not restart.
  - Jump and load-use are evaluated exactly as in IDLE.
  - Next state IDLE.
- Timing: a mul/div freezes the pipeline for exactly LAT cycles (1 in IDLE + LAT-1 in MD_RUN). The pipeline advances on cycle LAT+1.
- Back-to-back mul/div: the second is seen in IDLE after MD_DONE, giving a 1-cycle gap between freezes.
- StallCount: increments when PCWrite=0 and rst=0, saturates at 16'hFFFF.
- Reset mid-operation: the FSM returns to IDLE on that edge and no MD_DONE is produced.
- Illegal state encodings recover to IDLE on the next edge.

Test Plan:
- Load-use: EX_MemtoReg=1, EX_WR_out=5, ID_Rt=5, ID_Rs=3 -> PCWrite=0, IF_IDWrite=0, ID_Flush=1, IF_Flush=0; StallCount +1 per cycle. Repeat with EX_WR_out=0, ID_Rs=0 -> no stall.
- Jump + load-use together: EX_JumpOP=2'b01, EX_MemtoReg=1, EX_WR_out==ID_Rs=7 -> IF_Flush=1, ID_Flush=1, PCWrite=1, StallCount unchanged.
- Multiply: EX_MDReq=1, EX_MDIsDiv=0 held -> MD_Start high for cycle 1 only; PCWrite/ID_EXWrite=0 and MD_Busy=1 for cycles 1-4; cycle 5 all enables 1, no second MD_Start; StallCount=4.
- Divide back-to-back: two divides -> two 8-cycle freezes separated by one free cycle, two MD_Start pulses, StallCount=16.
- Reset mid-divide: rst=1 at freeze cycle 3 -> outputs at defaults immediately, state IDLE next edge, StallCount=0; a fresh EX_MDReq afterwards gives a full 8-cycle freeze.
- Saturation: force 65540 stall cycles (sustained load-use) -> StallCount holds 16'hFFFF.
